// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared forward-select codes, MDU state encoding and register constants
package hazard_scoreboard_pkg;
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam int REG_ZERO = 0;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } mdu_state_t;
endpackage

// File: rtl/hazard_scoreboard_mdu_scoreboard.sv
// mdu_scoreboard: tracks the single in-flight MDU op, its destination and its write-back cycle
module mdu_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [REG_AW-1:0] dst_in,
  output logic              busy,
  output logic              wb,
  output logic              pending,
  output logic [REG_AW-1:0] dst
);
  localparam int CW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
  localparam logic [CW-1:0] LOAD = CW'(MDU_LAT - 2);
  mdu_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [REG_AW-1:0] dst_n;
  // state, countdown and destination registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      dst   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dst   <= dst_n;
    end
  end
  // next-state: a start while BUSY is dropped; WB may accept a back-to-back start
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dst_n   = dst;
    if (state == IDLE && start) begin
      state_n = BUSY;
      cnt_n   = LOAD;
      dst_n   = dst_in;
    end else if (state == BUSY) begin
      state_n = (cnt == '0) ? WB : BUSY;
      cnt_n   = (cnt == '0) ? cnt : cnt - 1'b1;
    end else if (state == WB) begin
      state_n = start ? BUSY : IDLE;
      cnt_n   = start ? LOAD : cnt;
      dst_n   = start ? dst_in : dst;
    end
  end
  assign busy    = state != IDLE;
  assign wb      = state == WB;
  assign pending = busy & ~wb;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pipeline stall/flush, D and E forwarding, MDU scoreboard and stall counter
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_D,
  input  logic [REG_AW-1:0] rt_D,
  input  logic              use_rs_D,
  input  logic              use_rt_D,
  input  logic              if_branch_D,
  input  logic              mdu_req_D,
  input  logic [REG_AW-1:0] rs_E,
  input  logic [REG_AW-1:0] rt_E,
  input  logic              RegWr_E,
  input  logic              MemtoReg_E,
  input  logic [REG_AW-1:0] RegWrDst_E,
  input  logic              mdu_start_E,
  input  logic              RegWr_M,
  input  logic              MemtoReg_M,
  input  logic [REG_AW-1:0] RegWrDst_M,
  input  logic              RegWr_W,
  input  logic [REG_AW-1:0] RegWrDst_W,
  output logic              stall_F,
  output logic              stall_D,
  output logic              flush_E,
  output logic              fwd_rs_D,
  output logic              fwd_rt_D,
  output logic [1:0]        fwd_a_E,
  output logic [1:0]        fwd_b_E,
  output logic              mdu_busy,
  output logic              mdu_wb,
  output logic [REG_AW-1:0] mdu_dst,
  output logic [PERF_W-1:0] stall_cnt
);
  logic pending, load_use, br_haz, mdu_haz, mdu_struct, stall, alu_m;
  function automatic logic match(input logic [REG_AW-1:0] x, input logic [REG_AW-1:0] y);
    return (x == y) && (x != REG_AW'(REG_ZERO));
  endfunction
  mdu_scoreboard #(.REG_AW(REG_AW), .MDU_LAT(MDU_LAT)) u_mdu (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mdu_start_E),
    .dst_in (RegWrDst_E),
    .busy   (mdu_busy),
    .wb     (mdu_wb),
    .pending(pending),
    .dst    (mdu_dst)
  );
  assign load_use   = MemtoReg_E & ((use_rs_D & match(rs_D, RegWrDst_E)) | (use_rt_D & match(rt_D, RegWrDst_E)));
  assign br_haz     = if_branch_D & ((RegWr_E & (match(rs_D, RegWrDst_E) | match(rt_D, RegWrDst_E))) |
                                     (MemtoReg_M & (match(rs_D, RegWrDst_M) | match(rt_D, RegWrDst_M))));
  assign mdu_haz    = pending & ((use_rs_D & match(rs_D, mdu_dst)) | (use_rt_D & match(rt_D, mdu_dst)));
  assign mdu_struct = mdu_req_D & pending;
  assign stall      = load_use | br_haz | mdu_haz | mdu_struct;
  assign stall_F    = stall;
  assign stall_D    = stall;
  assign flush_E    = stall;
  assign alu_m      = RegWr_M & ~MemtoReg_M;
  assign fwd_rs_D   = if_branch_D & alu_m & match(rs_D, RegWrDst_M);
  assign fwd_rt_D   = if_branch_D & alu_m & match(rt_D, RegWrDst_M);
  assign fwd_a_E    = (alu_m & match(rs_E, RegWrDst_M)) ? FWD_MEM :
                      (RegWr_W & match(rs_E, RegWrDst_W)) ? FWD_WB : FWD_NONE;
  assign fwd_b_E    = (alu_m & match(rt_E, RegWrDst_M)) ? FWD_MEM :
                      (RegWr_W & match(rt_E, RegWrDst_W)) ? FWD_WB : FWD_NONE;
  // saturating count of stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (stall && ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors with hand-computed expectations
module tb_hazard_scoreboard;
  localparam int AW = 5;
  localparam int PW = 3;
  logic clk = 0, rst_n;
  logic [AW-1:0] rs_D, rt_D, rs_E, rt_E, RegWrDst_E, RegWrDst_M, RegWrDst_W, mdu_dst;
  logic use_rs_D, use_rt_D, if_branch_D, mdu_req_D, RegWr_E, MemtoReg_E, mdu_start_E;
  logic RegWr_M, MemtoReg_M, RegWr_W;
  logic stall_F, stall_D, flush_E, fwd_rs_D, fwd_rt_D, mdu_busy, mdu_wb;
  logic [1:0] fwd_a_E, fwd_b_E;
  logic [PW-1:0] stall_cnt;
  int total = 0, bad = 0;
  hazard_scoreboard #(.REG_AW(AW), .MDU_LAT(4), .PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .rs_D(rs_D), .rt_D(rt_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
    .if_branch_D(if_branch_D), .mdu_req_D(mdu_req_D), .rs_E(rs_E), .rt_E(rt_E), .RegWr_E(RegWr_E),
    .MemtoReg_E(MemtoReg_E), .RegWrDst_E(RegWrDst_E), .mdu_start_E(mdu_start_E), .RegWr_M(RegWr_M),
    .MemtoReg_M(MemtoReg_M), .RegWrDst_M(RegWrDst_M), .RegWr_W(RegWr_W), .RegWrDst_W(RegWrDst_W),
    .stall_F(stall_F), .stall_D(stall_D), .flush_E(flush_E), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E), .mdu_busy(mdu_busy), .mdu_wb(mdu_wb), .mdu_dst(mdu_dst),
    .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  // a start arriving while the MDU is still counting is illegal stimulus
  always @(posedge clk) if (rst_n && mdu_start_E && mdu_busy && !mdu_wb) $error("mdu_start_E while BUSY");
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    {rs_D, rt_D, rs_E, rt_E, RegWrDst_E, RegWrDst_M, RegWrDst_W} = '0;
    {use_rs_D, use_rt_D, if_branch_D, mdu_req_D, RegWr_E, MemtoReg_E, mdu_start_E} = '0;
    {RegWr_M, MemtoReg_M, RegWr_W} = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    clr();
    rst_n = 0;
    #12;
    chk("rst_stall", stall_F, 0);
    chk("rst_busy", mdu_busy, 0);
    chk("rst_cnt", stall_cnt, 0);
    tick();
    rst_n = 1;
    tick();
    MemtoReg_E = 1; RegWrDst_E = 2; rs_D = 2; use_rs_D = 1; rt_D = 4; use_rt_D = 1;
    #1;
    chk("lu_stall_F", stall_F, 1);
    chk("lu_stall_D", stall_D, 1);
    chk("lu_flush_E", flush_E, 1);
    chk("lu_cnt0", stall_cnt, 0);
    tick();
    clr();
    #1;
    chk("lu_cnt1", stall_cnt, 1);
    chk("lu_gone", stall_F, 0);
    MemtoReg_E = 1; RegWrDst_E = 2; rs_D = 2; use_rs_D = 0;
    #1;
    chk("lu_unused", stall_F, 0);
    clr();
    if_branch_D = 1; rs_D = 5; rt_D = 6; RegWr_E = 1; RegWrDst_E = 6;
    #1;
    chk("br_E_stall", stall_F, 1);
    tick();
    RegWr_E = 0; RegWrDst_E = 0; RegWr_M = 1; RegWrDst_M = 6;
    #1;
    chk("br_M_stall", stall_F, 0);
    chk("br_fwd_rt", fwd_rt_D, 1);
    chk("br_fwd_rs", fwd_rs_D, 0);
    MemtoReg_M = 1;
    #1;
    chk("br_ldM_stall", stall_F, 1);
    chk("br_ldM_fwd", fwd_rt_D, 0);
    clr();
    rs_E = 7; RegWr_M = 1; RegWrDst_M = 7; RegWr_W = 1; RegWrDst_W = 7;
    #1;
    chk("fa_mem", fwd_a_E, 2'b10);
    RegWr_M = 0;
    #1;
    chk("fa_wb", fwd_a_E, 2'b01);
    rt_E = 7; RegWr_M = 1; MemtoReg_M = 1;
    #1;
    chk("fb_ldM_wb", fwd_b_E, 2'b01);
    clr();
    MemtoReg_E = 1; RegWrDst_E = 0; rs_D = 0; use_rs_D = 1;
    #1;
    chk("z_lu", stall_F, 0);
    if_branch_D = 1; RegWr_M = 1; RegWrDst_M = 0; rs_E = 0; RegWr_W = 1; RegWrDst_W = 0;
    #1;
    chk("z_fwd_rs", fwd_rs_D, 0);
    chk("z_fwd_a", fwd_a_E, 0);
    chk("z_br", stall_F, 0);
    clr();
    chk("cnt_before_mdu", stall_cnt, 2);
    mdu_start_E = 1; RegWrDst_E = 9;
    #1;
    chk("c0_busy", mdu_busy, 0);
    tick();
    clr(); rs_D = 9; use_rs_D = 1;
    #1;
    chk("c1_busy", mdu_busy, 1);
    chk("c1_wb", mdu_wb, 0);
    chk("c1_dst", mdu_dst, 9);
    chk("c1_stall", stall_F, 1);
    tick();
    use_rs_D = 0; mdu_req_D = 1;
    #1;
    chk("c2_struct", stall_F, 1);
    chk("c2_wb", mdu_wb, 0);
    tick();
    mdu_req_D = 0; rt_D = 9; use_rt_D = 1;
    #1;
    chk("c3_stall", stall_F, 1);
    chk("c3_wb", mdu_wb, 0);
    tick();
    mdu_req_D = 1; mdu_start_E = 1; RegWrDst_E = 11;
    #1;
    chk("c4_wb", mdu_wb, 1);
    chk("c4_busy", mdu_busy, 1);
    chk("c4_nostall", stall_F, 0);
    tick();
    clr();
    #1;
    chk("c5_busy", mdu_busy, 1);
    chk("c5_wb", mdu_wb, 0);
    chk("c5_dst", mdu_dst, 11);
    chk("c5_cnt", stall_cnt, 5);
    tick();
    #2;
    rst_n = 0;
    #1;
    chk("ar_busy", mdu_busy, 0);
    chk("ar_wb", mdu_wb, 0);
    chk("ar_cnt", stall_cnt, 0);
    chk("ar_dst", mdu_dst, 0);
    tick();
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ar_nowb", {mdu_busy, mdu_wb}, 0);
    end
    MemtoReg_E = 1; RegWrDst_E = 3; rt_D = 3; use_rt_D = 1;
    for (int i = 0; i < 10; i++) tick();
    chk("sat_cnt", stall_cnt, 7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
